branch_target_unit: RTL and testbench
=====================================

Name: branch_target_unit

Overview:
- Drives the absolute-jump interface of the program counter: it generates BranchAbs and Target each cycle from the decoded branch controls.
- Targets come from a constant jump lookup table (LUT) indexed by the instruction, or from an internal return-address stack for call/return.
- It is the control-side partner of the program counter. It observes PrgCtr and decides the next fetch address.

Parameters:
- D, 12, program-counter and target width; must match the program counter's D
- L, 5, LUT index width (2^L table entries)
- S, 4, return-stack depth in entries (power of two, >= 2)

Ports:
- Clk  input  1  system clock; all state updates on posedge
- Reset  input  1  synchronous reset, active-high
- PrgCtr  input  D  current program counter value
- BranchEn  input  1  decoded conditional jump
- Cond  input  1  branch condition flag from ALU/flags register
- Call  input  1  decoded call: jump to LUT target, push return address
- Ret  input  1  decoded return: jump to popped address
- LutIdx  input  L  jump LUT index from the instruction field
- BranchAbs  output  1  absolute-jump enable to the program counter
- Target  output  D  jump target to the program counter
- Depth  output  $clog2(S)+1  current stack occupancy, 0..S
- StackOvf  output  1  sticky flag: a Call was issued while the stack was full
- StackUnf  output  1  sticky flag: a Ret was issued while the stack was empty

Behaviour:
- Timing: BranchAbs and Target are combinational from the current-cycle inputs and the stack top, so the program counter loads Target on the same edge. Zero added latency; there is no bubble.
- Stack pointer, storage and flags are registered.
- Priority when several controls are asserted: Ret > Call > BranchEn. Only the highest-priority operation acts.
- BranchEn:
  - BranchEn && Cond gives BranchAbs=1, Target=LUT[LutIdx].
  - BranchEn && !Cond gives BranchAbs=0.
- Call, stack not full:
  - BranchAbs=1, Target=LUT[LutIdx] (unconditional).
  - At the edge, push PrgCtr+1 truncated to D bits; wrap-around is legal (all-ones+1 gives 0). Depth increments.
- Call, stack full (Depth==S):
  - BranchAbs=0, so execution falls through.
  - No push, stack unchanged. StackOvf set at the edge.
- Ret, stack not empty:
  - BranchAbs=1, Target=stack top.
  - At the edge, pop; Depth decrements.
- Ret, stack empty (Depth==0):
  - BranchAbs=0, no pop. StackUnf set at the edge.
- Idle (no control asserted, or only BranchEn with Cond low): BranchAbs=0, state unchanged.
- Target when BranchAbs=0: drives LUT[LutIdx]. It is don't-care to the program counter but deterministic.
- Flags: StackOvf/StackUnf are sticky and clear only on Reset.
- Reset:
  - Forces BranchAbs=0 combinationally while asserted.
  - At the edge: Depth=0, StackOvf=0, StackUnf=0, all stack entries=0.
  - A Reset in the same cycle as Call/Ret wins: no push/pop and no flag set.
- Depth range: Depth never exceeds S and never goes below 0. The stack pointer is D-independent and held in $clog2(S)+1 bits.

Decomposition:
- Package branch_pkg holds:
  - the jump LUT as a localparam array of 2^L D-bit constants, with unused entries 0
  - the priority encoding as an enum op_t {OP_NONE, OP_JMP, OP_CALL, OP_RET}
- Sub-module return_stack holds the LIFO storage. Its interface:
  - inputs Clk, Reset, Push, Pop, PushData[D-1:0]
  - outputs Top[D-1:0], Full, Empty, Depth
- Push and Pop are never asserted together.
- The top level holds the op decode, the target mux and the sticky flags.

Test Plan:
- Reset, then idle with PrgCtr=12'h010 -> BranchAbs=0, Depth=0, StackOvf=0, StackUnf=0.
- BranchEn=1, Cond=1, LutIdx=2 -> BranchAbs=1, Target=LUT[2]. Repeat with Cond=0 -> BranchAbs=0.
- Call at PrgCtr=12'h020, LutIdx=3 -> BranchAbs=1, Target=LUT[3], Depth=1 next cycle. Then Ret -> BranchAbs=1, Target=12'h021, Depth=0.
- S+1 consecutive Calls at PrgCtr=12'h100..12'h104:
  - the first S calls branch; Depth reaches 4
  - the 5th call gives BranchAbs=0, StackOvf=1
  - then 4 Rets return 12'h104,12'h103,12'h102,12'h101 in order (the 5th call's address is never pushed; LIFO order is preserved).
- Ret with empty stack -> BranchAbs=0, StackUnf=1 next cycle and stays 1 until Reset.
- Call at PrgCtr=12'hFFF -> pushed 12'h000.
- Call+Ret+BranchEn asserted together with Depth=1 -> Ret wins, Depth=0.
- Reset asserted alongside Call -> Depth stays 0, BranchAbs=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch target unit: default sizes, the constant jump
// table and the per-cycle operation encoding.
package branch_pkg;

    localparam int BR_D = 12;
    localparam int BR_L = 5;
    localparam int BR_S = 4;

    // Jump targets selected by the instruction's LUT index; unused slots read as zero.
    localparam logic [BR_D-1:0] JUMP_LUT [0:(2**BR_L)-1] = '{
        0:       12'h080,
        1:       12'h0C0,
        2:       12'h200,
        3:       12'h340,
        4:       12'h4A0,
        5:       12'hFF0,
        default: 12'h000
    };

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_JMP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Depth counts occupied entries 0..S; Top is the most
// recently pushed entry and is meaningless while Empty.
module return_stack #(
    parameter int D = 12,
    parameter int S = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Push,
    input  logic                   Pop,
    input  logic [D-1:0]           PushData,
    output logic [D-1:0]           Top,
    output logic                   Full,
    output logic                   Empty,
    output logic [$clog2(S):0]     Depth
);

    localparam int AW = $clog2(S);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] ONE_D    = DW'(1);
    localparam logic [DW-1:0] FULL_LVL = DW'(S);
    localparam logic [AW-1:0] ONE_A    = AW'(1);

    logic [D-1:0]  mem_q [S];
    logic [D-1:0]  mem_d [S];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [AW-1:0] top_idx;

    always_comb begin
        top_idx = depth_q[AW-1:0] - ONE_A;
        Full    = (depth_q == FULL_LVL);
        Empty   = (depth_q == '0);
        Top     = mem_q[top_idx];
        Depth   = depth_q;
    end

    // Guarding on Full/Empty here keeps the pointer in range even if the caller misbehaves.
    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (Push && !Full) begin
            mem_d[depth_q[AW-1:0]] = PushData;
            depth_d                = depth_q + ONE_D;
        end else if (Pop && !Empty) begin
            depth_d = depth_q - ONE_D;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            depth_q <= '0;
            for (int i = 0; i < S; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/branch_target_unit.sv
// Absolute-jump control for the program counter: decodes branch/call/return with
// Ret > Call > BranchEn priority and drives BranchAbs/Target in the same cycle.
module branch_target_unit
    import branch_pkg::*;
#(
    parameter int D = BR_D,
    parameter int L = BR_L,
    parameter int S = BR_S
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [D-1:0]           PrgCtr,
    input  logic                   BranchEn,
    input  logic                   Cond,
    input  logic                   Call,
    input  logic                   Ret,
    input  logic [L-1:0]           LutIdx,
    output logic                   BranchAbs,
    output logic [D-1:0]           Target,
    output logic [$clog2(S):0]     Depth,
    output logic                   StackOvf,
    output logic                   StackUnf
);

    localparam logic [D-1:0] ONE_PC = D'(1);

    op_t          op;
    logic         push;
    logic         pop;
    logic         stk_full;
    logic         stk_empty;
    logic [D-1:0] stk_top;
    logic [D-1:0] lut_target;
    logic         ovf_q;
    logic         ovf_d;
    logic         unf_q;
    logic         unf_d;

    always_comb begin
        op = OP_NONE;
        if (Ret) begin
            op = OP_RET;
        end else if (Call) begin
            op = OP_CALL;
        end else if (BranchEn && Cond) begin
            op = OP_JMP;
        end
    end

    // Reset suppresses both the jump and any stack side effect in the same cycle.
    always_comb begin
        lut_target = JUMP_LUT[LutIdx];
        push       = !Reset && (op == OP_CALL) && !stk_full;
        pop        = !Reset && (op == OP_RET) && !stk_empty;
        BranchAbs  = !Reset && ((op == OP_JMP) || push || pop);
        Target     = pop ? stk_top : lut_target;
    end

    always_comb begin
        ovf_d = ovf_q || (!Reset && (op == OP_CALL) && stk_full);
        unf_d = unf_q || (!Reset && (op == OP_RET) && stk_empty);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign StackOvf = ovf_q;
    assign StackUnf = unf_q;

    return_stack #(
        .D (D),
        .S (S)
    ) u_return_stack (
        .Clk      (Clk),
        .Reset    (Reset),
        .Push     (push),
        .Pop      (pop),
        .PushData (PrgCtr + ONE_PC),
        .Top      (stk_top),
        .Full     (stk_full),
        .Empty    (stk_empty),
        .Depth    (Depth)
    );

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: combinational outputs are checked 1ns after
// inputs change mid-cycle, registered state 1ns after the following rising edge.
module tb_branch_target_unit;

    localparam int D = 12;
    localparam int L = 5;
    localparam int S = 4;

    localparam logic [D-1:0] LUT2 = 12'h200;
    localparam logic [D-1:0] LUT3 = 12'h340;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [D-1:0]  PrgCtr;
    logic          BranchEn;
    logic          Cond;
    logic          Call;
    logic          Ret;
    logic [L-1:0]  LutIdx;
    logic          BranchAbs;
    logic [D-1:0]  Target;
    logic [2:0]    Depth;
    logic          StackOvf;
    logic          StackUnf;

    int checks = 0;
    int errors = 0;

    branch_target_unit #(.D(D), .L(L), .S(S)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .PrgCtr    (PrgCtr),
        .BranchEn  (BranchEn),
        .Cond      (Cond),
        .Call      (Call),
        .Ret       (Ret),
        .LutIdx    (LutIdx),
        .BranchAbs (BranchAbs),
        .Target    (Target),
        .Depth     (Depth),
        .StackOvf  (StackOvf),
        .StackUnf  (StackUnf)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [D-1:0] pc, input logic br,
                         input logic cnd, input logic cl, input logic rt, input logic [L-1:0] idx);
        Reset    = rst;
        PrgCtr   = pc;
        BranchEn = br;
        Cond     = cnd;
        Call     = cl;
        Ret      = rt;
        LutIdx   = idx;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();

        drive(1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_val("idle_abs", 16'(BranchAbs), 16'h0);
        check_val("rst_depth", 16'(Depth), 16'h0);
        check_val("rst_ovf", 16'(StackOvf), 16'h0);
        check_val("rst_unf", 16'(StackUnf), 16'h0);

        drive(1'b0, 12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2);
        check_val("jmp_abs", 16'(BranchAbs), 16'h1);
        check_val("jmp_tgt", 16'(Target), 16'(LUT2));
        tick();
        drive(1'b0, 12'h011, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2);
        check_val("nojmp_abs", 16'(BranchAbs), 16'h0);
        check_val("nojmp_tgt", 16'(Target), 16'(LUT2));
        tick();
        check_val("nojmp_depth", 16'(Depth), 16'h0);

        drive(1'b0, 12'h020, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        check_val("call_abs", 16'(BranchAbs), 16'h1);
        check_val("call_tgt", 16'(Target), 16'(LUT3));
        tick();
        drive(1'b0, 12'h340, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        check_val("call_depth", 16'(Depth), 16'h1);
        drive(1'b0, 12'h341, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check_val("ret_abs", 16'(BranchAbs), 16'h1);
        check_val("ret_tgt", 16'(Target), 16'h021);
        tick();
        check_val("ret_depth", 16'(Depth), 16'h0);

        for (int i = 0; i <= S; i++) begin
            drive(1'b0, 12'(12'h100 + i), 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
            check_val("fill_abs", 16'(BranchAbs), (i < S) ? 16'h1 : 16'h0);
            tick();
            check_val("fill_depth", 16'(Depth), (i < S) ? 16'(i + 1) : 16'(S));
        end
        check_val("ovf_set", 16'(StackOvf), 16'h1);
        check_val("ovf_no_unf", 16'(StackUnf), 16'h0);

        for (int j = 0; j < S; j++) begin
            drive(1'b0, 12'h300, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
            check_val("drain_abs", 16'(BranchAbs), 16'h1);
            check_val("drain_tgt", 16'(Target), 16'(12'h104 - j));
            tick();
        end
        check_val("drain_depth", 16'(Depth), 16'h0);

        drive(1'b0, 12'h300, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
        check_val("unf_abs", 16'(BranchAbs), 16'h0);
        check_val("unf_tgt", 16'(Target), 16'(LUT2));
        tick();
        check_val("unf_set", 16'(StackUnf), 16'h1);
        check_val("unf_depth", 16'(Depth), 16'h0);
        drive(1'b0, 12'h301, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick();
        check_val("unf_sticky", 16'(StackUnf), 16'h1);
        check_val("ovf_sticky", 16'(StackOvf), 16'h1);

        drive(1'b0, 12'hFFF, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        check_val("wrap_call_abs", 16'(BranchAbs), 16'h1);
        tick();
        drive(1'b0, 12'h340, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check_val("wrap_ret_tgt", 16'(Target), 16'h000);
        check_val("wrap_ret_abs", 16'(BranchAbs), 16'h1);
        tick();

        drive(1'b0, 12'h050, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        tick();
        check_val("prio_pre_depth", 16'(Depth), 16'h1);
        drive(1'b0, 12'h340, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2);
        check_val("prio_abs", 16'(BranchAbs), 16'h1);
        check_val("prio_tgt", 16'(Target), 16'h051);
        tick();
        check_val("prio_depth", 16'(Depth), 16'h0);

        drive(1'b1, 12'h060, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        check_val("rstcall_abs", 16'(BranchAbs), 16'h0);
        tick();
        check_val("rstcall_depth", 16'(Depth), 16'h0);
        check_val("rstcall_ovf", 16'(StackOvf), 16'h0);
        check_val("rstcall_unf", 16'(StackUnf), 16'h0);

        drive(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check_val("post_rst_ret_abs", 16'(BranchAbs), 16'h0);
        tick();
        check_val("post_rst_unf", 16'(StackUnf), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
